// File: rtl/term_loopback_cfg.sv
`default_nettype none
// ============================================================================
// Module   : term_loopback_cfg
// Brief    : Fabric edge-termination tile. Loops N_END wire groups back onto
//            S_BEG with a per-group mode (pass / registered / tie-off / LFSR)
//            held in double-buffered configuration bits (shadow/active).
//            Frame strobes and the user clock pass through to the next tile.
// Revision : 1.0 - initial release
// ============================================================================
module term_loopback_cfg #(
    parameter int          NUM_GROUPS = 4,
    parameter int          GROUP_W    = 8,
    parameter int          FRAME_BITS = 32,
    parameter int          MAX_FRAMES = 20,
    parameter int          CFG_FRAME  = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic                          MODE,
    input  logic [FRAME_BITS-1:0]         FrameData,
    input  logic [MAX_FRAMES-1:0]         FrameStrobe,
    output logic [MAX_FRAMES-1:0]         FrameStrobe_O,
    input  logic                          UserCLK,
    output logic                          UserCLKo,
    input  logic [NUM_GROUPS*GROUP_W-1:0] N_END,
    output logic [NUM_GROUPS*GROUP_W-1:0] S_BEG,
    output logic [2*NUM_GROUPS-1:0]       CfgActive_O
);

    localparam int c_CFG_W = 2 * NUM_GROUPS;
    localparam int c_BUS_W = NUM_GROUPS * GROUP_W;

    localparam logic [1:0] c_M_PASS = 2'b00;
    localparam logic [1:0] c_M_REG  = 2'b01;
    localparam logic [1:0] c_M_TIE  = 2'b10;
    localparam logic [1:0] c_M_LFSR = 2'b11;

    logic [c_CFG_W-1:0] shadow_q, shadow_d;
    logic [c_CFG_W-1:0] active_q, active_d;
    logic               mode_q,   mode_d;
    logic [c_BUS_W-1:0] n_q,      n_d;
    logic [15:0]        lfsr_q,   lfsr_d;
    logic               w_lfsr_fb;

    // Column pass-through of strobes and user clock, no logic in the path.
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;
    assign CfgActive_O   = active_q;

    // Taps for x^16+x^14+x^13+x^11+1 in shift-left Fibonacci form.
    assign w_lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Next-state: shadow load on strobe, commit shadow->active on MODE fall.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        lfsr_d   = lfsr_q;
        mode_d   = MODE;
        n_d      = N_END;
        if (FrameStrobe[CFG_FRAME]) begin
            shadow_d = FrameData[c_CFG_W-1:0];
        end
        // Commit uses the pre-edge shadow, so a same-cycle write waits for
        // the next commit.
        if (mode_q && !MODE) begin
            active_d = shadow_q;
        end
        if (!MODE) begin
            lfsr_d = {lfsr_q[14:0], w_lfsr_fb};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            shadow_q <= '0;
            active_q <= '0;
            mode_q   <= 1'b0;
            n_q      <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Per-group output mux driven by the active mode bits.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        logic [1:0]         w_m;
        logic [GROUP_W-1:0] w_out;

        assign w_m = active_q[2*g +: 2];

        // Configuration mode forces every group low regardless of its mode.
        always_comb begin
            w_out = '0;
            if (!MODE) begin
                case (w_m)
                    c_M_PASS: w_out = N_END[g*GROUP_W +: GROUP_W];
                    c_M_REG:  w_out = n_q[g*GROUP_W +: GROUP_W];
                    c_M_TIE:  w_out = '0;
                    c_M_LFSR: w_out = lfsr_q[GROUP_W-1:0];
                    default:  w_out = '0;
                endcase
            end
        end

        assign S_BEG[g*GROUP_W +: GROUP_W] = w_out;
    end

    // FrameData bits above the mode field belong to other consumers.
    if (FRAME_BITS > c_CFG_W) begin : g_unused_fd
        logic unused_framedata;
        assign unused_framedata = ^FrameData[FRAME_BITS-1:c_CFG_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_term_loopback_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_term_loopback_cfg
// Brief    : Self-checking bench for term_loopback_cfg: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_term_loopback_cfg;

    logic        CLK;
    logic        RESETn;
    logic        MODE;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [19:0] FrameStrobe_O;
    logic        UserCLK;
    logic        UserCLKo;
    logic [31:0] N_END;
    logic [31:0] S_BEG;
    logic [7:0]  CfgActive_O;

    int n_cmp;
    int n_err;

    // Behavioural model state
    logic [7:0]  m_shadow;
    logic [7:0]  m_active;
    logic        m_prev_mode;
    logic [31:0] m_prev_n;
    logic [15:0] m_lfsr;

    term_loopback_cfg dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .MODE          (MODE),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O),
        .UserCLK       (UserCLK),
        .UserCLKo      (UserCLKo),
        .N_END         (N_END),
        .S_BEG         (S_BEG),
        .CfgActive_O   (CfgActive_O)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shadow    = 8'h00;
        m_active    = 8'h00;
        m_prev_mode = 1'b0;
        m_prev_n    = 32'h0;
        m_lfsr      = 16'hACE1;
    endtask

    // Expected S_BEG: each group's byte chosen by its 2-bit mode number.
    function automatic logic [31:0] model_sbeg();
        logic [31:0] r;
        int          sel;
        r = 32'h0;
        if (MODE) return r;
        for (int g = 0; g < 4; g++) begin
            sel = (int'(m_active) >> (2 * g)) % 4;
            if (sel == 0)      r[g*8 +: 8] = N_END[g*8 +: 8];
            else if (sel == 1) r[g*8 +: 8] = m_prev_n[g*8 +: 8];
            else if (sel == 2) r[g*8 +: 8] = 8'h00;
            else               r[g*8 +: 8] = m_lfsr[7:0];
        end
        return r;
    endfunction

    // One rising edge: update the model from the inputs present at the edge.
    task automatic clk_edge();
        logic [7:0] old_shadow;
        logic       tap;
        @(posedge CLK);
        if (!RESETn) begin
            model_reset();
        end else begin
            old_shadow = m_shadow;
            if (FrameStrobe[0]) m_shadow = FrameData[7:0];
            if (m_prev_mode && !MODE) m_active = old_shadow;
            m_prev_mode = MODE;
            m_prev_n    = N_END;
            if (!MODE) begin
                tap    = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
                m_lfsr = (m_lfsr << 1) | 16'(tap);
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_sbeg"}, S_BEG, model_sbeg());
        check_val({tag, "_cfg"}, {24'h0, CfgActive_O}, {24'h0, m_active});
        check_val({tag, "_fso"}, {12'h0, FrameStrobe_O}, {12'h0, FrameStrobe});
        check_val({tag, "_uclk"}, {31'h0, UserCLKo}, {31'h0, UserCLK});
    endtask

    task automatic set_in(input logic md, input logic stb, input logic [31:0] fd, input logic [31:0] ne);
        MODE        = md;
        FrameStrobe = {19'h0, stb};
        FrameData   = fd;
        N_END       = ne;
        #1;
    endtask

    initial begin
        logic [19:0] fs;
        n_cmp       = 0;
        n_err       = 0;
        RESETn      = 1'b0;
        MODE        = 1'b0;
        FrameData   = 32'h0;
        FrameStrobe = 20'h0;
        UserCLK     = 1'b0;
        N_END       = 32'hDEADBEEF;
        model_reset();
        #2;

        // T1: reset state, pass-through while held in reset
        check_val("t1_sbeg", S_BEG, 32'hDEADBEEF);
        check_val("t1_cfg", {24'h0, CfgActive_O}, 32'h0);
        clk_edge();
        check_all("t1_edge");
        RESETn = 1'b1;

        // T2: write lands in shadow only; commit on MODE fall
        set_in(1'b1, 1'b1, 32'h000000E4, 32'h11223344);
        check_val("t2_cfgmode_sbeg", S_BEG, 32'h0);
        clk_edge();
        check_val("t2_shadow_cfg", {24'h0, CfgActive_O}, 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 32'h11223344);
        check_val("t2_precommit_cfg", {24'h0, CfgActive_O}, 32'h0);
        clk_edge();
        check_val("t2_commit_cfg", {24'h0, CfgActive_O}, 32'hE4);
        check_all("t2");

        // T3: mixed modes on one bus
        set_in(1'b0, 1'b0, 32'h0, 32'h55667788);
        check_val("t3_g0_pass", {24'h0, S_BEG[7:0]}, 32'h88);
        check_val("t3_g1_old", {24'h0, S_BEG[15:8]}, 32'h33);
        check_val("t3_g2_tie", {24'h0, S_BEG[23:16]}, 32'h0);
        check_all("t3");
        clk_edge();
        check_val("t3_g1_reg", {24'h0, S_BEG[15:8]}, 32'h77);
        check_all("t3_edge");

        // T4: LFSR sequence on all groups after a fresh reset
        RESETn = 1'b0;
        #1;
        model_reset();
        check_all("t4_rst");
        set_in(1'b1, 1'b1, 32'h000000FF, 32'hA5A5A5A5);
        RESETn = 1'b1;
        clk_edge();
        set_in(1'b0, 1'b0, 32'h0, 32'hA5A5A5A5);
        clk_edge();
        check_val("t4_lfsr1", S_BEG, 32'hC3C3C3C3);
        clk_edge();
        check_val("t4_lfsr2", S_BEG, 32'h87878787);
        check_all("t4");

        // T5: write on the commit cycle defers to the next commit
        set_in(1'b1, 1'b1, 32'h000000E4, 32'h01020304);
        clk_edge();
        set_in(1'b0, 1'b1, 32'h000000FF, 32'h01020304);
        clk_edge();
        check_val("t5_same_cycle", {24'h0, CfgActive_O}, 32'hE4);
        set_in(1'b1, 1'b0, 32'h0, 32'h01020304);
        clk_edge();
        check_val("t5_held", {24'h0, CfgActive_O}, 32'hE4);
        set_in(1'b0, 1'b0, 32'h0, 32'h01020304);
        clk_edge();
        check_val("t5_second", {24'h0, CfgActive_O}, 32'hFF);

        // T6: async reset mid-run in LFSR mode
        clk_edge();
        N_END  = 32'hCAFEF00D;
        RESETn = 1'b0;
        #1;
        model_reset();
        check_val("t6_sbeg", S_BEG, 32'hCAFEF00D);
        check_val("t6_cfg", {24'h0, CfgActive_O}, 32'h0);
        clk_edge();
        RESETn = 1'b1;
        check_all("t6_rel");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) MODE = ~MODE;
            fs    = 20'($urandom);
            fs[0] = ($urandom_range(0, 2) == 0);
            FrameStrobe = fs;
            FrameData   = $urandom;
            N_END       = $urandom;
            UserCLK     = 1'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                RESETn = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                clk_edge();
                RESETn = 1'b1;
            end
            #1;
            check_all("rnd_pre");
            clk_edge();
            check_all("rnd_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
